lstm_seq_ctrl: RTL

//  Address/write-enable sequencer for the two-layer LSTM datapath. Replaces

---
 rtl/lstm_seq_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - address/write-enable sequencer for the two-layer LSTM datapath
// Layer 2 trails layer 1 by one pass; a final drain pass runs layer 2 alone.
module lstm_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int AW          = 9,
    parameter int TIMESTEP    = 7,
    parameter int LAYR1_INPUT = 53,
    parameter int LAYR1_CELL  = 53,
    parameter int LAYR2_CELL  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] addr_x1,
    output logic [AW-1:0]    rd_addr_h1,
    output logic [AW-1:0]    rd_addr_c1,
    output logic             wr_h1,
    output logic             wr_c1,
    output logic [AW-1:0]    wr_addr_h1,
    output logic [AW-1:0]    wr_addr_c1,
    output logic [AW-1:0]    rd_addr_layr1,
    output logic [AW-1:0]    wr_addr_layr1,
    output logic             wr_layr1,
    output logic             wr_x2,
    output logic [AW-1:0]    wr_addr_x2,
    output logic [AW-1:0]    rd_addr_x2,
    output logic [AW-1:0]    rd_addr_h2,
    output logic [AW-1:0]    rd_addr_c2,
    output logic             wr_h2,
    output logic             wr_c2,
    output logic [AW-1:0]    wr_addr_h2,
    output logic [AW-1:0]    wr_addr_c2,
    output logic [AW-1:0]    rd_addr_layr2,
    output logic [AW-1:0]    wr_addr_layr2,
    output logic             wr_layr2
);

    localparam int PW       = $clog2(TIMESTEP + 1);
    localparam int KW       = $clog2(LAYR1_CELL + 1);
    localparam int DRAIN_K0 = LAYR1_CELL - LAYR2_CELL;

    localparam logic [31:0] TS_U  = TIMESTEP;
    localparam logic [31:0] LI_U  = LAYR1_INPUT;
    localparam logic [31:0] L1C_U = LAYR1_CELL;
    localparam logic [31:0] L2C_U = LAYR2_CELL;
    localparam logic [31:0] DK0_U = DRAIN_K0;

    if ((TIMESTEP + 1) * LAYR1_CELL > (1 << AW)) begin : g_aw_check
        $error("lstm_seq_ctrl: (TIMESTEP+1)*LAYR1_CELL does not fit in AW bits");
    end
    if (LAYR2_CELL > LAYR1_CELL) begin : g_cell_check
        $error("lstm_seq_ctrl: LAYR2_CELL must not exceed LAYR1_CELL");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [KW-1:0] k_q, k_d;

    logic [31:0] p_w, k_w, j_w;
    logic        run, l1_act, l2_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    p_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    if (k_q == KW'(LAYR1_CELL - 1)) begin
                        if (p_q == PW'(TIMESTEP)) begin
                            state_d = S_DONE;
                            p_d     = '0;
                            k_d     = '0;
                        end else begin
                            p_d = p_q + PW'(1);
                            // the drain pass only covers the cells feeding layer 2
                            k_d = (p_q == PW'(TIMESTEP - 1)) ? KW'(DRAIN_K0) : '0;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign p_w    = 32'(p_q);
    assign k_w    = 32'(k_q);
    assign j_w    = k_w - DK0_U;
    assign run    = (state_q == S_RUN);
    assign l1_act = run && (p_w < TS_U);
    assign l2_act = run && (p_w != 32'd0) && (k_w >= DK0_U);

    always_comb begin
        busy          = run;
        done          = (state_q == S_DONE);
        addr_x1       = '0;
        rd_addr_h1    = '0;
        rd_addr_c1    = '0;
        wr_h1         = 1'b0;
        wr_c1         = 1'b0;
        wr_addr_h1    = '0;
        wr_addr_c1    = '0;
        rd_addr_layr1 = '0;
        wr_addr_layr1 = '0;
        wr_layr1      = 1'b0;
        wr_x2         = 1'b0;
        wr_addr_x2    = '0;
        rd_addr_x2    = '0;
        rd_addr_h2    = '0;
        rd_addr_c2    = '0;
        wr_h2         = 1'b0;
        wr_c2         = 1'b0;
        wr_addr_h2    = '0;
        wr_addr_c2    = '0;
        rd_addr_layr2 = '0;
        wr_addr_layr2 = '0;
        wr_layr2      = 1'b0;

        if (l1_act) begin
            addr_x1       = WIDTH'(p_w * LI_U);
            rd_addr_h1    = AW'(p_w * L1C_U);
            rd_addr_c1    = AW'(p_w * L1C_U);
            wr_addr_h1    = AW'((p_w + 32'd1) * L1C_U + k_w);
            wr_addr_c1    = AW'((p_w + 32'd1) * L1C_U + k_w);
            rd_addr_layr1 = AW'(k_w);
            wr_addr_x2    = AW'(p_w * L1C_U + k_w);
            wr_h1         = !hold;
            wr_c1         = !hold;
            wr_x2         = !hold;
        end

        if (l2_act) begin
            rd_addr_x2    = AW'((p_w - 32'd1) * L1C_U);
            rd_addr_h2    = AW'((p_w - 32'd1) * L2C_U);
            rd_addr_c2    = AW'((p_w - 32'd1) * L2C_U);
            wr_addr_h2    = AW'(p_w * L2C_U + j_w);
            wr_addr_c2    = AW'(p_w * L2C_U + j_w);
            rd_addr_layr2 = AW'(j_w);
            wr_h2         = !hold;
            wr_c2         = !hold;
        end
    end

endmodule
